// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and pointer-width helper for the synchronous FIFO.
package fifo_pkg;

    localparam int FIFO_DATA_W_DEF = 37;
    localparam int FIFO_DEPTH_DEF  = 8;

    // Pointers carry one extra wrap bit so that full and empty can be told apart.
    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DATA_W x DEPTH register array, one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W_DEF,
    parameter int DEPTH  = FIFO_DEPTH_DEF,
    parameter int ADDR_W = fifo_ptr_w(DEPTH) - 1
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock show-ahead FIFO with occupancy and threshold flags.
// Define FIFO_ERR_EN to add sticky overflow/underflow flags with an err_clr input.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W_DEF,
    parameter int DEPTH  = FIFO_DEPTH_DEF,
    parameter int AF_TH  = DEPTH - 1,
    parameter int AE_TH  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        w_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        r_data,
    output logic                     not_full,
    output logic                     not_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    output logic                     almost_empty
`ifdef FIFO_ERR_EN
    ,
    input  logic                     err_clr,
    output logic                     overflow,
    output logic                     underflow
`endif
);

    localparam int PTR_W  = fifo_ptr_w(DEPTH);
    localparam int ADDR_W = PTR_W - 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] AF_TH_C  = PTR_W'(AF_TH);
    localparam logic [PTR_W-1:0] AE_TH_C  = PTR_W'(AE_TH);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              full, empty;
    logic              wr_acc, rd_acc;
    logic [DATA_W-1:0] mem_rdata;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                   (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

    assign not_full  = ~full;
    assign not_empty = ~empty;

    // Acceptance uses registered flags only, so a write into an empty FIFO
    // never falls through to r_data and a read of a full FIFO blocks the write.
    assign wr_acc = wr_en && not_full;
    assign rd_acc = rd_en && not_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign count        = wr_ptr_q - rd_ptr_q;
    assign almost_full  = (count >= AF_TH_C);
    assign almost_empty = (count <= AE_TH_C);

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wr_ptr_q[ADDR_W-1:0]),
        .wr_data_i (w_data),
        .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
        .rd_data_o (mem_rdata)
    );

    assign r_data = rd_acc ? mem_rdata : '0;

`ifdef FIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // err_clr takes priority over a set in the same cycle.
    always_comb begin
        overflow_d  = overflow_q  | (wr_en & full);
        underflow_d = underflow_q | (rd_en & empty);
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo: directed scenarios plus randomized traffic against a queue model.
// Builds with or without FIFO_ERR_EN.
module tb_param_sync_fifo;

    localparam int DW    = 37;
    localparam int DEPTH = 8;
    localparam int AF    = 7;
    localparam int AE    = 1;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] w_data;
    logic          rd_en;
    logic [DW-1:0] r_data;
    logic          not_full;
    logic          not_empty;
    logic [3:0]    count;
    logic          almost_full;
    logic          almost_empty;
`ifdef FIFO_ERR_EN
    logic          err_clr;
    logic          overflow;
    logic          underflow;
    logic          m_ovf;
    logic          m_unf;
`endif

    int errors = 0;
    int checks = 0;
    logic run_cmp = 1'b0;
    logic [DW-1:0] q[$];

    param_sync_fifo #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .AF_TH  (AF),
        .AE_TH  (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .w_data       (w_data),
        .rd_en        (rd_en),
        .r_data       (r_data),
        .not_full     (not_full),
        .not_empty    (not_empty),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`ifdef FIFO_ERR_EN
        ,
        .err_clr      (err_clr),
        .overflow     (overflow),
        .underflow    (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of accepted entries, updated at each edge.
    initial begin : model
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                q.delete();
`ifdef FIFO_ERR_EN
                m_ovf = 1'b0;
                m_unf = 1'b0;
`endif
            end else begin
                int n;
                logic do_rd, do_wr;
                n = q.size();
`ifdef FIFO_ERR_EN
                if (err_clr) begin
                    m_ovf = 1'b0;
                    m_unf = 1'b0;
                end else begin
                    if (wr_en && n == DEPTH) m_ovf = 1'b1;
                    if (rd_en && n == 0)     m_unf = 1'b1;
                end
`endif
                do_rd = rd_en && (n > 0);
                do_wr = wr_en && (n < DEPTH);
                if (do_rd) void'(q.pop_front());
                if (do_wr) q.push_back(w_data);
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (run_cmp && !rst) begin
                int n;
                logic [DW-1:0] exp_r;
                n = q.size();
                exp_r = (rd_en && n > 0) ? q[0] : '0;
                chk("m_r_data", r_data, exp_r);
                chk("m_count", count, n);
                chk("m_not_full", not_full, n < DEPTH);
                chk("m_not_empty", not_empty, n > 0);
                chk("m_almost_full", almost_full, n >= AF);
                chk("m_almost_empty", almost_empty, n <= AE);
`ifdef FIFO_ERR_EN
                chk("m_overflow", overflow, m_ovf);
                chk("m_underflow", underflow, m_unf);
`endif
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    // Inputs change just after a rising edge; the call returns just after the
    // following falling edge, where combinational outputs for them are settled.
    task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r);
        @(posedge clk);
        #1;
        wr_en  = w;
        w_data = d;
        rd_en  = r;
        @(negedge clk);
        #1;
    endtask

    initial begin : stim
        logic [DW-1:0] d;
        rst = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        w_data = '0;
`ifdef FIFO_ERR_EN
        err_clr = 1'b0;
`endif
        #1;
        chk("rst_count", count, 0);
        chk("rst_not_empty", not_empty, 0);
        chk("rst_not_full", not_full, 1);
        chk("rst_almost_empty", almost_empty, 1);
        chk("rst_almost_full", almost_full, 0);
        chk("rst_r_data", r_data, 0);
`ifdef FIFO_ERR_EN
        chk("rst_overflow", overflow, 0);
        chk("rst_underflow", underflow, 0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_cmp = 1'b1;

        // Fill with 1..8, then one rejected write.
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, DW'(i), 1'b0);
            chk("fill_count", count, i - 1);
            chk("fill_af", almost_full, (i - 1) >= 7);
        end
        cyc(1'b1, DW'(9), 1'b0);
        chk("full_count", count, 8);
        chk("full_not_full", not_full, 0);
        chk("full_af", almost_full, 1);
        cyc(1'b0, '0, 1'b0);
        chk("overfill_count", count, 8);
`ifdef FIFO_ERR_EN
        chk("overflow_set", overflow, 1);
`endif

        // Drain in order, then one extra read on empty.
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, '0, 1'b1);
            chk("drain_r_data", r_data, i);
        end
        cyc(1'b0, '0, 1'b1);
        chk("empty_r_data", r_data, 0);
        chk("empty_not_empty", not_empty, 0);
        chk("empty_count", count, 0);
        cyc(1'b0, '0, 1'b0);
`ifdef FIFO_ERR_EN
        chk("underflow_set", underflow, 1);
        err_clr = 1'b1;
        cyc(1'b0, '0, 1'b0);
        err_clr = 1'b0;
        chk("overflow_clr", overflow, 0);
        chk("underflow_clr", underflow, 0);
`endif

        // Empty with simultaneous read and write: no fall-through.
        cyc(1'b1, DW'('h55), 1'b1);
        chk("empty_rw_r_data", r_data, 0);
        cyc(1'b0, '0, 1'b1);
        chk("empty_rw_count", count, 1);
        chk("empty_rw_next", r_data, 'h55);
        cyc(1'b0, '0, 1'b0);
        chk("empty_rw_after", count, 0);

        // Full with simultaneous read and write: write blocked.
        for (int i = 1; i <= 8; i++) cyc(1'b1, DW'(i), 1'b0);
        cyc(1'b1, DW'('hAA), 1'b1);
        chk("full_rw_r_data", r_data, 1);
        chk("full_rw_count0", count, 8);
        cyc(1'b0, '0, 1'b0);
        chk("full_rw_count1", count, 7);
        for (int i = 2; i <= 8; i++) begin
            cyc(1'b0, '0, 1'b1);
            chk("full_rw_drain", r_data, i);
        end
        cyc(1'b0, '0, 1'b0);
        chk("full_rw_empty", not_empty, 0);

        // Steady streaming at occupancy 3, pointers wrap several times.
        for (int i = 0; i < 3; i++) cyc(1'b1, DW'('h100 + i), 1'b0);
        for (int j = 0; j < 20; j++) begin
            cyc(1'b1, DW'('h103 + j), 1'b1);
            chk("stream_count", count, 3);
            chk("stream_r_data", r_data, 'h100 + j);
        end

        // Reset in the middle of a burst at occupancy 5.
        cyc(1'b1, DW'('h200), 1'b0);
        cyc(1'b1, DW'('h201), 1'b0);
        cyc(1'b1, DW'('h202), 1'b1);
        chk("pre_rst_count", count, 5);
        rst = 1'b1;
        #1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_not_empty", not_empty, 0);
        chk("mid_rst_not_full", not_full, 1);
        chk("mid_rst_r_data", r_data, 0);
        chk("mid_rst_ae", almost_empty, 1);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        rst = 1'b0;
        cyc(1'b1, DW'('h77), 1'b0);
        chk("post_rst_count", count, 0);
        cyc(1'b0, '0, 1'b1);
        chk("post_rst_r_data", r_data, 'h77);
        cyc(1'b0, '0, 1'b0);
        chk("post_rst_empty", count, 0);

        // Randomized traffic with phases of different write/read bias.
        for (int ph = 0; ph < 16; ph++) begin
            int pw, pr;
            pw = $urandom_range(10, 90);
            pr = $urandom_range(10, 90);
            for (int k = 0; k < 100; k++) begin
                d = DW'({$urandom(), $urandom()});
                cyc(($urandom_range(99) < pw), d, ($urandom_range(99) < pr));
`ifdef FIFO_ERR_EN
                err_clr = ($urandom_range(15) == 0);
`endif
            end
        end

        cyc(1'b0, '0, 1'b0);
        run_cmp = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter DATA_W, default 37, payload width in bits (>=1).
REQ-002 Parameter DEPTH, default 8, entry count; SHALL be a power of two >=2.
REQ-003 Parameter AF_TH, default DEPTH-1, almost-full threshold in entries (1..DEPTH).
REQ-004 Parameter AE_TH, default 1, almost-empty threshold in entries (0..DEPTH-1).
REQ-005 clk  input  1  sole clock; all state rising-edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 wr_en  input  1  write request.
REQ-008 w_data  input  DATA_W  write payload.
REQ-009 rd_en  input  1  read request.
REQ-010 r_data  output  DATA_W  head entry, valid when read accepted.
REQ-011 not_full  output  1  write will be accepted.
REQ-012 not_empty  output  1  read will be accepted.
REQ-013 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-014 almost_full  output  1  count >= AF_TH.
REQ-015 almost_empty  output  1  count <= AE_TH.
REQ-016 With FIFO_ERR_EN only: err_clr input 1, overflow output 1, underflow output 1.

Function
REQ-017 Write accepted iff wr_en && not_full; w_data stored at write pointer on that edge, write pointer +1.
REQ-018 Read accepted iff rd_en && not_empty; read pointer +1 on that edge.
REQ-019 r_data SHALL be combinational: head entry when read accepted, else all zeros (zero-latency, show-ahead).
REQ-020 Pointers ADDR_W+1 bits (ADDR_W=$clog2(DEPTH)); address = low ADDR_W bits; wrap from DEPTH-1 to 0 with MSB toggle.
REQ-021 empty = pointers equal; full = low bits equal and MSBs differ; not_full/not_empty are inversions, combinational from registered pointers.
REQ-022 count = wr_ptr - rd_ptr modulo 2^(ADDR_W+1); almost_full/almost_empty combinational from count.
REQ-023 Simultaneous accepted read and write: count unchanged, both pointers advance.
REQ-024 When full, simultaneous rd_en and wr_en: read accepted, write rejected (not_full sampled low), count DEPTH-1 next cycle.
REQ-025 When empty, simultaneous rd_en and wr_en: write accepted, read rejected, r_data zero; no fall-through of w_data.
REQ-026 Rejected requests SHALL not modify any state.

Reset
REQ-027 rst asserted: pointers 0, count 0, not_empty 0, not_full 1, almost_empty 1, almost_full 0, r_data 0, overflow/underflow 0.
REQ-028 Reset mid-operation discards all contents immediately; storage array is not reset and is unobservable until rewritten.

Configuration
REQ-029 Macro FIFO_ERR_EN defined: overflow sets on wr_en while full, underflow sets on rd_en while empty; both sticky until err_clr=1 (clear wins over same-cycle set).
REQ-030 FIFO_ERR_EN undefined: err_clr, overflow, underflow ports and logic absent; all other behaviour identical.

Structure
REQ-031 Package fifo_pkg SHALL hold default constants (FIFO_DATA_W_DEF=37, FIFO_DEPTH_DEF=8) and a function for pointer width.
REQ-032 Storage SHALL be sub-module fifo_mem (DATA_W x DEPTH register array, one write port, one async read port); control stays in param_sync_fifo.

Verification (DATA_W=37, DEPTH=8, AF_TH=7, AE_TH=1)
REQ-033 Reset, then 8 writes 0x1..0x8 -> not_full=0 after 8th, count=8, almost_full from 7th; 9th write ignored, overflow=1 (ERR_EN).
REQ-034 8 reads after fill -> r_data 0x1..0x8 in order on read cycles, not_empty=0 after last, extra read gives r_data=0, underflow=1.
REQ-035 Full, rd_en=wr_en=1 with w_data=0xAA -> r_data=0x1, count=7, 0xAA not stored.
REQ-036 Empty, rd_en=wr_en=1 with w_data=0x55 -> r_data=0, count=1, next read returns 0x55.
REQ-037 20 cycles of continuous write+read at count=3 -> count stays 3, pointers wrap past 15, data order preserved.
REQ-038 rst pulse at count=5 mid-burst -> count=0, not_empty=0, not_full=1 same cycle; subsequent write/read returns new data only.
